// File: rtl/score_display_ctrl_pkg.sv
// score_display_ctrl_pkg: shared states and constants for the score display controller
package score_display_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER_SCORE, OVER_HIGH} state_t;
  localparam logic [13:0] BLANK_CODE = 14'h3FFF;
  localparam int SCORE_W = 5;
  localparam int SCORE_MAX = 31;
endpackage

// File: rtl/score_display_ctrl_tick_phase_timer.sv
// tick_phase_timer: tick-driven dwell and blink counters with terminal-count strobes
module tick_phase_timer #(
  parameter int DWELL_TICKS = 8,
  parameter int BLINK_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clr,
  input  logic seed,
  output logic dwell_done,
  output logic blink_done
);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] blink_cnt;
  assign dwell_done = tick && dwell_cnt == DW'(DWELL_TICKS - 1);
  assign blink_done = tick && blink_cnt == BW'(BLINK_TICKS - 1);
  // seed lets a tick that lands on a state change count toward the new state
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      blink_cnt <= '0;
    end else if (clr) begin
      dwell_cnt <= DW'(seed);
      blink_cnt <= BW'(seed);
    end else if (tick) begin
      dwell_cnt <= dwell_done ? '0 : dwell_cnt + DW'(1);
      blink_cnt <= blink_done ? '0 : blink_cnt + BW'(1);
    end
  end
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: game score tracking and two-digit display sequencing with post-game blink/alternate
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int DWELL_TICKS = 8,
  parameter int BLINK_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               eat,
  input  logic               game_over,
  input  logic [13:0]        seg_code,
  output logic [SCORE_W-1:0] sel_value,
  output logic [13:0]        hex_out,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);
  state_t state, state_n;
  logic blank, blank_n, dwell_done, blink_done, swap, clr, over;
  logic [SCORE_W-1:0] score_inc, score_play;
  tick_phase_timer #(.DWELL_TICKS(DWELL_TICKS), .BLINK_TICKS(BLINK_TICKS)) u_timer (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .clr(clr),
    .seed(tick && !swap),
    .dwell_done(dwell_done),
    .blink_done(blink_done)
  );
  always_comb begin
    over = state == OVER_SCORE || state == OVER_HIGH;
    swap = over && dwell_done && !start;
    score_inc = score == SCORE_W'(SCORE_MAX) ? score : score + SCORE_W'(1);
    score_play = eat ? score_inc : score;
    state_n = start ? PLAY :
              (state == PLAY && game_over) ? OVER_SCORE :
              !swap ? state :
              (state == OVER_SCORE) ? OVER_HIGH : OVER_SCORE;
    clr = state_n != state;
    blank_n = clr ? 1'b0 : (state == OVER_SCORE && blink_done) ? ~blank : blank;
    sel_value = (state == PLAY || state == OVER_SCORE) ? score : high_score;
  end
  // the increment is folded in before the game-over high-score compare
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      score <= '0;
      high_score <= '0;
      blank <= 1'b0;
      hex_out <= BLANK_CODE;
    end else begin
      state <= state_n;
      blank <= blank_n;
      hex_out <= blank_n ? BLANK_CODE : seg_code;
      if (start) score <= '0;
      else if (state == PLAY) score <= score_play;
      if (!start && state == PLAY && game_over && score_play > high_score) high_score <= score_play;
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: table vectors, directed corner sequences and random stimulus against a reference model
module tb_score_display_ctrl;
  import score_display_ctrl_pkg::*;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_OS = 2, M_OH = 3;
  localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic clk = 0, rst = 1, tick = 0, start = 0, eat = 0, game_over = 0;
  logic [13:0] seg_code, hex_out;
  logic [4:0] sel_value, score, high_score;
  int checks = 0, errors = 0;
  int m_mode = M_IDLE, m_score = 0, m_hs = 0, m_t = 0;
  bit m_blank = 0;
  logic [13:0] m_hex = 14'h3FFF;

  typedef struct {
    bit r, s, e, g, t;
    int sc, hs, sel, hv;
    bit bl;
  } vec_t;

  vec_t tbl [20] = '{
    '{1,0,0,0,0, 0,0,0,0,1}, '{0,0,1,1,0, 0,0,0,0,0}, '{0,1,0,0,0, 0,0,0,0,0},
    '{0,0,1,0,0, 1,0,1,0,0}, '{0,0,1,0,0, 2,0,2,1,0}, '{0,0,1,0,0, 3,0,3,2,0},
    '{0,0,0,0,0, 3,0,3,3,0}, '{0,0,1,1,0, 4,4,4,3,0}, '{0,0,0,0,0, 4,4,4,4,0},
    '{0,1,1,0,0, 0,4,0,4,0}, '{0,0,1,0,0, 1,4,1,0,0}, '{0,0,1,0,0, 2,4,2,1,0},
    '{0,0,1,0,0, 3,4,3,2,0}, '{0,0,1,0,0, 4,4,4,3,0}, '{0,0,1,0,0, 5,4,5,4,0},
    '{0,1,1,0,0, 0,4,0,5,0}, '{0,0,1,0,0, 1,4,1,0,0}, '{0,0,0,1,0, 1,4,1,1,0},
    '{0,0,0,0,1, 1,4,1,1,0}, '{0,1,0,0,0, 0,4,0,1,0}
  };

  function automatic logic [13:0] seg(input logic [4:0] v);
    return {DIG[v / 10], DIG[v % 10]};
  endfunction

  assign seg_code = seg(sel_value);

  score_display_ctrl #(.DWELL_TICKS(DW), .BLINK_TICKS(BL)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .eat(eat), .game_over(game_over),
    .seg_code(seg_code), .sel_value(sel_value), .hex_out(hex_out), .score(score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  function automatic int m_sel();
    return (m_mode == M_PLAY || m_mode == M_OS) ? m_score : m_hs;
  endfunction

  // reference: phase length and blink derived from ticks counted since state entry
  task automatic model(input bit r, s, e, g, t);
    int old_sel = m_sel();
    int nm = m_mode;
    bit by_dwell = 0;
    if (r) begin
      m_mode = M_IDLE; m_score = 0; m_hs = 0; m_t = 0; m_blank = 0; m_hex = 14'h3FFF;
      return;
    end
    if (s) begin
      nm = M_PLAY; m_score = 0;
    end else if (m_mode == M_PLAY) begin
      if (e && m_score < 31) m_score++;
      if (g) begin
        nm = M_OS;
        if (m_score > m_hs) m_hs = m_score;
      end
    end else if ((m_mode == M_OS || m_mode == M_OH) && t && m_t + 1 == DW) begin
      nm = (m_mode == M_OS) ? M_OH : M_OS;
      by_dwell = 1;
    end
    if (nm != m_mode) m_t = (t && !by_dwell) ? 1 : 0;
    else if (t) m_t++;
    m_mode = nm;
    m_blank = m_mode == M_OS && (m_t / BL) % 2 == 1;
    m_hex = m_blank ? 14'h3FFF : seg(5'(old_sel));
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, s, e, g, t);
    @(negedge clk);
    rst = r; start = s; eat = e; game_over = g; tick = t;
    model(r, s, e, g, t);
    @(posedge clk);
    #1;
    chk("model score", 32'(score), 32'(m_score));
    chk("model high_score", 32'(high_score), 32'(m_hs));
    chk("model sel_value", 32'(sel_value), 32'(m_sel()));
    chk("model hex_out", 32'(hex_out), 32'(m_hex));
  endtask

  initial begin
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].g, tbl[i].t);
      chk($sformatf("vec%0d score", i), 32'(score), 32'(tbl[i].sc));
      chk($sformatf("vec%0d high_score", i), 32'(high_score), 32'(tbl[i].hs));
      chk($sformatf("vec%0d sel_value", i), 32'(sel_value), 32'(tbl[i].sel));
      chk($sformatf("vec%0d hex_out", i), 32'(hex_out), tbl[i].bl ? 32'h3FFF : 32'(seg(5'(tbl[i].hv))));
    end
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    repeat (35) apply(0, 0, 1, 0, 0);
    chk("saturate score", 32'(score), 31);
    chk("saturate sel", 32'(sel_value), 31);
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    repeat (4) apply(0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0);
    chk("first hs", 32'(high_score), 4);
    apply(0, 1, 0, 0, 0);
    repeat (7) apply(0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0);
    chk("hs loads 7", 32'(high_score), 7);
    chk("over visible", 32'(hex_out), 32'(seg(5'd7)));
    repeat (4) apply(0, 0, 0, 0, 1);
    chk("blank after 4 ticks", 32'(hex_out), 32'h3FFF);
    repeat (4) apply(0, 0, 0, 0, 1);
    chk("over_high sel", 32'(sel_value), 7);
    chk("over_high visible", 32'(hex_out), 32'(seg(5'd7)));
    repeat (4) apply(0, 0, 0, 0, 1);
    chk("over_high no blank", 32'(hex_out), 32'(seg(5'd7)));
    apply(0, 1, 0, 0, 0);
    repeat (2) apply(0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0);
    chk("hs kept 7", 32'(high_score), 7);
    chk("score 2 kept", 32'(score), 2);
    repeat (4) apply(0, 0, 0, 0, 1);
    chk("blanked before rst", 32'(hex_out), 32'h3FFF);
    apply(1, 0, 0, 0, 0);
    chk("rst hex", 32'(hex_out), 32'h3FFF);
    chk("rst score", 32'(score), 0);
    chk("rst hs", 32'(high_score), 0);
    chk("rst sel", 32'(sel_value), 0);
    for (int i = 0; i < 3000; i++)
      apply($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these parameters, one per line as name, default, meaning:
- DWELL_TICKS, 8: ticks per alternation phase after game over.
- BLINK_TICKS, 4: ticks per blink half-period.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- tick, in, 1: single-cycle timebase enable.
- start, in, 1: new-game pulse.
- eat, in, 1: food-eaten pulse.
- game_over, in, 1: game-over pulse.
- seg_code, in, 14: code returned by the shared two-digit 7-segment transcoder.
- sel_value, out, 5: value driven to the transcoder input.
- hex_out, out, 14: registered segment drive, {tens[6:0], ones[6:0]}, active-low.
- score, out, 5: current score.
- high_score, out, 5: best score since reset.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, PLAY, OVER_SCORE and OVER_HIGH.
REQ-005 IDLE SHALL go to PLAY on start; game_over and eat SHALL be ignored in IDLE.
REQ-006 PLAY SHALL go to OVER_SCORE on game_over.
REQ-007 A start in PLAY SHALL clear score and keep the FSM in PLAY.
REQ-008 OVER_SCORE and OVER_HIGH SHALL swap after every DWELL_TICKS tick pulses.
REQ-009 start in either OVER state SHALL go to PLAY and clear score.
REQ-010 On eat in PLAY, score SHALL increment by 1 and saturate at 31; there is no wrap to 0.
REQ-011 When start and eat are both asserted, start SHALL win: score becomes 0 and the eat is dropped.
REQ-012 When eat and game_over are both asserted in PLAY, the increment SHALL be applied before the game-over evaluation.
REQ-013 On the PLAY-to-OVER_SCORE transition, high_score SHALL load the final score if it is strictly greater; high_score is otherwise unchanged.
REQ-014 sel_value SHALL equal score in PLAY and OVER_SCORE.
REQ-015 sel_value SHALL equal high_score in IDLE and OVER_HIGH.
REQ-016 sel_value SHALL be decoded combinationally from registered state.
REQ-017 hex_out SHALL register seg_code, giving one clk of latency from a sel_value change to hex_out.
REQ-018 hex_out SHALL be 14'h3FFF (all segments off) while the blank flag is set.
REQ-019 The blank flag SHALL toggle every BLINK_TICKS ticks, only in OVER_SCORE.
REQ-020 The blank flag SHALL clear on every state entry; OVER_SCORE therefore starts visible.
REQ-021 OVER_HIGH, PLAY and IDLE SHALL never blank.
REQ-022 The dwell and blink counters SHALL advance only on tick.
REQ-023 The dwell and blink counters SHALL reset to 0 on every state change.
REQ-024 A tick coincident with a state change SHALL count toward the new state.

Reset
REQ-025 While rst is high, the FSM SHALL be in IDLE.
REQ-026 While rst is high, score, high_score, the counters and the blank flag SHALL be 0.
REQ-027 The first clock edge with rst high SHALL load hex_out with 14'h3FFF.
REQ-028 Reset SHALL take priority over every other input.
REQ-029 A reset asserted mid-game SHALL discard the game score without updating high_score.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the BLANK_CODE constant (14'h3FFF), SCORE_W = 5 and SCORE_MAX = 31.
REQ-031 The transcoder SHALL remain external and is connected through sel_value and seg_code.
REQ-032 One sub-module, tick_phase_timer, SHALL implement the dwell counter and the blink counter with their terminal-count strobes.

Verification
REQ-033 The bench SHALL check: reset, then start, then 3 eat pulses -> score = 3, sel_value = 3, hex_out follows seg_code one cycle later.
REQ-034 The bench SHALL check: 35 eat pulses in PLAY -> score saturates at 31.
REQ-035 The bench SHALL check: score 7, game_over with high_score 4 -> high_score = 7 and OVER_SCORE is entered visible; after 4 ticks hex_out = 3FFF; after 8 ticks the FSM is in OVER_HIGH with sel_value = 7 and no blanking.
REQ-036 The bench SHALL check: score 2, game_over with high_score 7 -> high_score stays 7.
REQ-037 The bench SHALL check: start and eat in the same cycle during PLAY with score 5 -> score = 0.
REQ-038 The bench SHALL check: rst asserted in OVER_SCORE while blanked -> IDLE, score = 0, high_score = 0, hex_out = 3FFF on the next edge.
